// File: rtl/banco_reg_op.sv
// Register bank with an integrated add/multiply unit: the result of X op Y is
// written into one of NREGS registers, and SEL reads one register back on R.
module banco_reg_op #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 16,
    parameter int NREGS  = 8,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] X,
    input  logic [DATA_W-1:0] Y,
    input  logic              C,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic              en_addr,
    input  logic [ADDR_W-1:0] SEL,
    output logic [RES_W-1:0]  R
);

    logic [RES_W-1:0] op;
    logic [NREGS-1:0] we;
    logic [RES_W-1:0] regs [NREGS];

    // Both operands are widened first, so the add keeps its carry in bit DATA_W
    // and the multiply produces the full-width product.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        op = '0;
        if (C) begin
            op = RES_W'(X) * RES_W'(Y);
        end else begin
            op = RES_W'(X) + RES_W'(Y);
        end
    end

    // One-hot write decoder; all zeros when writes are disabled.
    always_comb begin
        we = '0;
        if (en_addr) begin
            we[w_addr] = 1'b1;
        end
    end

    // NOTE: the bank is a small flop array rather than a RAM, so every entry
    // can be cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                // NOTE: non-blocking assignment, so a read in the same cycle sees the old value.
                if (we[i]) begin
                    regs[i] <= op;
                end
            end
        end
    end

    assign R = regs[SEL];

endmodule

// File: tb/tb_banco_reg_op.sv
// Self-checking bench for banco_reg_op: directed cases plus randomized writes,
// compared against an array model of the register bank.
module tb_banco_reg_op;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  X, Y;
    logic        C;
    logic [2:0]  w_addr, SEL;
    logic        en_addr;
    logic [15:0] R;

    int errors = 0;
    int checks = 0;
    logic [15:0] model [8];

    always #20 clk = ~clk;

    banco_reg_op dut (
        .clk     (clk),
        .reset   (reset),
        .X       (X),
        .Y       (Y),
        .C       (C),
        .w_addr  (w_addr),
        .en_addr (en_addr),
        .SEL     (SEL),
        .R       (R)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_op(input int unsigned x, input int unsigned y, input bit c);
        int unsigned v;
        v = c ? x * y : x + y;
        return v[15:0];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    endtask

    task automatic read_one(input string tag, input int sel);
        SEL = sel[2:0];
        #1;
        check(tag, R, model[sel]);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 8; i++) read_one(tag, i);
    endtask

    // Inputs are set at the falling edge; R of the target register is checked
    // just before the rising edge (old value) and just after it (new value).
    task automatic write(input logic [7:0] x, input logic [7:0] y, input bit c,
                         input logic [2:0] addr, input bit en);
        @(negedge clk);
        X = x; Y = y; C = c; w_addr = addr; en_addr = en; SEL = addr;
        #10;
        check("pre_edge_old", R, model[addr]);
        @(posedge clk);
        if (en && reset) model[addr] = ref_op(x, y, c);
        #2;
        check("post_edge_new", R, model[addr]);
        en_addr = 1'b0;
    endtask

    initial begin
        clear_model();
        reset = 1'b0;
        X = 8'($urandom); Y = 8'($urandom); C = 1'($urandom);
        w_addr = 3'($urandom); SEL = 3'($urandom); en_addr = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        read_all("reset_all_zero");

        @(negedge clk);
        reset = 1'b1;
        en_addr = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        read_all("idle_after_reset");

        // Multiply into reg5
        write(8'h0F, 8'hF0, 1'b1, 3'd5, 1'b1);
        SEL = 3'd5; #1; check("mul_reg5", R, 16'h0E10);
        SEL = 3'd4; #1; check("reg4_untouched", R, 16'h0000);

        // Disabled write, then add with carry into reg2
        write(8'h0F, 8'hF0, 1'b0, 3'd2, 1'b0);
        SEL = 3'd2; #1; check("no_write_reg2", R, 16'h0000);
        write(8'hF0, 8'h55, 1'b0, 3'd2, 1'b1);
        SEL = 3'd2; #1; check("add_carry_reg2", R, 16'h0145);

        // Multiply overwrite of reg2
        write(8'hF0, 8'h55, 1'b1, 3'd2, 1'b1);
        SEL = 3'd2; #1; check("mul_overwrite_reg2", R, 16'h4FB0);
        SEL = 3'd5; #1; check("reg5_kept", R, 16'h0E10);

        // Extremes into reg0 and reg7
        write(8'hFF, 8'hFF, 1'b1, 3'd0, 1'b1);
        write(8'hFF, 8'hFF, 1'b0, 3'd7, 1'b1);
        SEL = 3'd0; #1; check("max_mul_reg0", R, 16'hFE01);
        SEL = 3'd7; #1; check("max_add_reg7", R, 16'h01FE);

        // Operands change mid-cycle: only the values at the edge are captured
        @(negedge clk);
        X = 8'd1; Y = 8'd2; C = 1'b0; w_addr = 3'd3; en_addr = 1'b1;
        #10;
        X = 8'd3; Y = 8'd4; C = 1'b1;
        @(posedge clk);
        model[3] = ref_op(3, 4, 1'b1);
        #2;
        en_addr = 1'b0;
        SEL = 3'd3; #1; check("mid_cycle_change", R, 16'h000C);
        read_all("bank_before_reset");

        // Async reset between edges, with a write pending while held in reset
        @(negedge clk);
        X = 8'h12; Y = 8'h34; C = 1'b1; w_addr = 3'd4; en_addr = 1'b1;
        #5;
        reset = 1'b0;
        clear_model();
        read_all("async_reset_clear");
        @(posedge clk);
        #2;
        read_all("write_during_reset");
        @(negedge clk);
        en_addr = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        read_all("after_reset_release");

        // Randomized writes with occasional full readback and reset pulses
        for (int n = 0; n < 300; n++) begin
            write(8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
                  $urandom_range(0, 3) != 0);
            if (n % 25 == 24) read_all("rand_readback");
            if ($urandom_range(0, 39) == 0) begin
                #3;
                reset = 1'b0;
                clear_model();
                read_all("rand_async_reset");
                reset = 1'b1;
            end
        end
        #2;
        read_all("final_readback");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
